muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, parametrised in operand width.
- Sits beside the integer ALU in the core's execute stage.
- The core asserts start with funct3 and two operands, stalls on busy, and writes out to rd on done.
- Adds M-extension support that the single-cycle ALU path lacks, at a fixed multi-cycle latency.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies with a zero operand complete in one cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_CALC | one multiply/divide iteration per clock
  // S_FIN  | result on out, done high; may accept a new start
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q, opb_q;
  logic [2:0]        op_q;
  logic              neg_q, neg_r_q;

  logic              accept;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              fast;
  logic [XLEN-1:0]   fast_res;

  assign accept = start && (state_q != S_CALC);

  always_comb begin
    a_sgn = in1[XLEN-1] && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    b_sgn = in2[XLEN-1] && (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
    mag_a = a_sgn ? -in1 : in1;
    mag_b = b_sgn ? -in2 : in2;
  end

  // Single-cycle results: divide by zero, signed overflow, optional zero-multiply.
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (funct3[2]) begin
      if (in2 == '0) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? in1 : '1;
      end else if (!funct3[0] && in1 == MIN_NEG && in2 == '1) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? '0 : in1;
      end
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (in1 == '0 || in2 == '0) begin
      fast     = 1'b1;
      fast_res = '0;
    end
`endif
  end

  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;

  // hi/lo hold accumulator:multiplier for multiply, remainder:dividend-quotient for divide.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_sh  = {hi_q, lo_q[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opb_q};
    if (op_q[2]) begin
      hi_nxt = div_ge ? XLEN'(div_sh - {1'b0, opb_q}) : div_sh[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, calc_res;

  always_comb begin
    prod = neg_q   ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    quo  = neg_q   ? -lo_nxt : lo_nxt;
    rem  = neg_r_q ? -hi_nxt : hi_nxt;
    case (op_q)
      3'b000:                 calc_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = quo;
      default:                calc_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = fast ? S_FIN : S_CALC;
      S_CALC:  if (cnt_q == LAST) state_d = S_FIN;
      S_FIN:   state_d = start ? (fast ? S_FIN : S_CALC) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      out     <= '0;
    end else if (accept) begin
      op_q    <= funct3;
      neg_q   <= a_sgn ^ b_sgn;
      neg_r_q <= a_sgn;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= funct3[2] ? mag_a : mag_b;
      opb_q   <= funct3[2] ? mag_b : mag_a;
      if (fast) out <= fast_res;
    end else if (state_q == S_CALC) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST) out <= calc_res;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_FIN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus directed and randomized operations.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] in1 = '0, in2 = '0;
  logic        busy, done;
  logic [31:0] out;

  logic        start16 = 1'b0;
  logic [2:0]  f16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [15:0] out16;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out));

  muldiv_unit #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .funct3(f16), .in1(a16), .in2(b16),
    .busy(busy16), .done(done16), .out(out16));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int w);
    return v[w-1] ? (v | ~((64'd1 << w) - 64'd1)) : v;
  endfunction

  // RV32M result from plain integer arithmetic on w-bit operands.
  function automatic logic [63:0] model(input int w, input logic [2:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    longint sa, sb, p;
    logic [63:0] mask, minv, r;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    sa = $signed(sx(a, w));
    sb = $signed(sx(b, w));
    case (op)
      3'd0: begin p = sa * sb; r = p; end
      3'd1: begin p = sa * sb; r = p >>> w; end
      3'd2: begin p = sa * $signed(b); r = p >>> w; end
      3'd3: r = (a * b) >> w;
      3'd4: begin
        if (b == 0) r = mask;
        else if (a == minv && b == mask) r = a;
        else begin p = sa / sb; r = p; end
      end
      3'd5: r = (b == 0) ? mask : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == minv && b == mask) r = 0;
        else begin p = sa % sb; r = p; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r & mask;
  endfunction

  function automatic bit is_fast(input int w, input logic [2:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    if (op[2]) return (b == 0) || (!op[0] && a == minv && b == mask);
`ifdef MULDIV_EARLY_OUT_EN
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Timing model for the 32-bit unit: cycles of busy remaining, done pulse, held result.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_out = '0, m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_out <= m_pend;
    end else if (start) begin
      if (is_fast(32, funct3, 64'(in1), 64'(in2))) begin
        m_done <= 1'b1;
        m_out  <= 32'(model(32, funct3, 64'(in1), 64'(in2)));
      end else begin
        m_pend <= 32'(model(32, funct3, 64'(in1), 64'(in2)));
        m_left <= 32;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("out", 64'(out), 64'(m_out));
  end

  // Caller is at a negedge; returns at the negedge of the done cycle with start low.
  task automatic op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit noise, output logic [31:0] res, output int bcnt, output int lat);
    funct3 = op; in1 = a; in2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); in1 = $urandom; in2 = $urandom;
    bcnt = 0; lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) begin
        bcnt++;
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          funct3 = 3'($urandom); in1 = $urandom; in2 = $urandom;
        end
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    res = out;
  endtask

  task automatic op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] res, output int bcnt, output int lat);
    f16 = op; a16 = a; b16 = b; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    bcnt = 0; lat = 1;
    while (done16 !== 1'b1 && lat < 60) begin
      if (busy16 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("done16_seen", 64'(done16), 64'd1);
    res = out16;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a, b, e;
    bit          fast;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] r, a, b;
    logic [15:0] r16, x16, y16;
    logic [2:0]  op;
    int          bc, lt, nd;
    bit          f;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    op32(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, r, bc, lt);
    chk("mul_7_m3", 64'(r), 64'hFFFF_FFEB);
    chk("mul_busy_cycles", 64'(bc), 64'd32);
    chk("mul_latency", 64'(lt), 64'd33);
    @(negedge clk);
    chk("mul_single_done", 64'(done), 64'd0);

    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 1'b0});
    vecs.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 1'b0});
    vecs.push_back('{3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{3'd6, 32'h1234, 32'd0, 32'h1234, 1'b1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1});
`ifdef MULDIV_EARLY_OUT_EN
    vecs.push_back('{3'd0, 32'd0, 32'd5, 32'd0, 1'b1});
`else
    vecs.push_back('{3'd0, 32'd0, 32'd5, 32'd0, 1'b0});
`endif

    // Back-to-back: each op is issued in the done cycle of the previous one.
    foreach (vecs[i]) begin
      chk($sformatf("model_pin%0d", i), model(32, vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b)),
          64'(vecs[i].e));
      op32(vecs[i].op, vecs[i].a, vecs[i].b, 1'(i % 2), r, bc, lt);
      chk($sformatf("vec%0d_res", i), 64'(r), 64'(vecs[i].e));
      chk($sformatf("vec%0d_busy", i), 64'(bc), vecs[i].fast ? 64'd0 : 64'd32);
      chk($sformatf("vec%0d_lat", i), 64'(lt), vecs[i].fast ? 64'd1 : 64'd33);
    end
    @(negedge clk);

    // Reset in the tenth CALC cycle of a divide.
    funct3 = 3'd4; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_out", 64'(out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no_done_after_rst", 64'(nd), 64'd0);

    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom);
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0:       r = 32'd0;
          1:       r = 32'h8000_0000;
          2:       r = 32'hFFFF_FFFF;
          3:       r = 32'($urandom_range(1, 20));
          default: r = $urandom;
        endcase
        if (k == 0) a = r; else b = r;
      end
      f = is_fast(32, op, 64'(a), 64'(b));
      op32(op, a, b, 1'($urandom_range(0, 1)), r, bc, lt);
      chk($sformatf("rnd%0d_op%0d_res", i, op), 64'(r), model(32, op, 64'(a), 64'(b)));
      chk($sformatf("rnd%0d_lat", i), 64'(lt), f ? 64'd1 : 64'd33);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    op16(3'd0, 16'h0100, 16'h0100, r16, bc, lt);
    chk("x16_mul", 64'(r16), 64'h0000);
    chk("x16_busy_cycles", 64'(bc), 64'd16);
    chk("x16_latency", 64'(lt), 64'd17);
    @(negedge clk);
    op16(3'd3, 16'h0100, 16'h0100, r16, bc, lt);
    chk("x16_mulhu", 64'(r16), 64'h0001);
    chk("x16_mulhu_busy", 64'(bc), 64'd16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      op = 3'($urandom);
      x16 = 16'($urandom);
      y16 = (i % 4 == 0) ? 16'hFFFF : 16'($urandom);
      op16(op, x16, y16, r16, bc, lt);
      chk($sformatf("x16_rnd%0d_op%0d", i, op), 64'(r16), model(16, op, 64'(x16), 64'(y16)));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched",
             n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
